// File: rtl/pixel_burst_writer_pkg.sv
// Shared definitions for the pixel burst writer: frame geometry, FIFO sizing,
// FSM encoding and the FIFO entry layout.
package pixel_burst_writer_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int ADDR_W     = 19;
   localparam int DEPTH_LOG2 = 5;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int BURST_LEN  = 8;
   localparam int FLUSH_CYC  = 16;

   localparam int CNT_W  = DEPTH_LOG2 + 1;
   localparam int RUN_W  = $clog2(BURST_LEN + 1);
   localparam int IDLE_W = $clog2(FLUSH_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} pbw_state_t;

   // Everything the drain side needs about the head word.
   typedef struct packed {
      logic              eof;
      logic [ADDR_W-1:0] addr;
      logic [23:0]       data;
   } pbw_payload_t;

   // sol sits in the MSB so the FIFO can expose it separately for head+1.
   typedef struct packed {
      logic         sol;
      pbw_payload_t pl;
   } pbw_entry_t;

   localparam int ENTRY_W = $bits(pbw_entry_t);

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
      return ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
   endfunction

endpackage

// File: rtl/pixel_burst_writer_if.sv
// Pixel input stream plus frame-buffer write bus and status flags.
interface pixel_burst_writer_if;
   import pixel_burst_writer_pkg::*;

   logic              wrreq;
   logic [9:0]        x_i, y_i;
   logic [7:0]        red_i, green_i, blue_i;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [31:0]       mem_wdata;
   logic              mem_wvalid;
   logic              mem_wlast;
   logic              mem_wready;
   logic              overflow;
   logic              frame_done;

   modport master (
      input  wrreq, x_i, y_i, red_i, green_i, blue_i, mem_ack, mem_wready,
      output mem_req, mem_addr, mem_wdata, mem_wvalid, mem_wlast, overflow, frame_done
   );

   modport slave (
      output wrreq, x_i, y_i, red_i, green_i, blue_i, mem_ack, mem_wready,
      input  mem_req, mem_addr, mem_wdata, mem_wvalid, mem_wlast, overflow, frame_done
   );

endinterface

// File: rtl/pixel_burst_writer_fifo.sv
// Register-file FIFO. Read port 0 returns the head payload (all but the MSB),
// read port 1 returns only the MSB flag of the entry behind the head.
// The caller guarantees no push when full and no pop when empty.
module pbw_fifo #(
   parameter int W  = 8,
   parameter int AW = 5
) (
   input  logic          clk_25,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-2:0]  o_head,
   output logic          o_head1_flag,
   output logic [AW:0]   o_count
);

   localparam int DEPTH = 1 << AW;
   localparam int CW    = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_count;
   logic [AW-1:0] w_rptr1;

   assign w_rptr1      = r_rptr + 1'b1;
   assign o_head       = r_mem[r_rptr][W-2:0];
   assign o_head1_flag = r_mem[w_rptr1][W-1];
   assign o_count      = r_count;

   // Storage: no reset, stale contents are unreachable once pointers clear.
   always_ff @(posedge clk_25) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk_25) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

endmodule

// File: rtl/pixel_burst_writer.sv
// Maps incoming pixels to linear frame-buffer addresses, buffers them and
// drains them as contiguous write bursts to the memory controller.
module pixel_burst_writer
   import pixel_burst_writer_pkg::*;
(
   input  logic                 clk_25,
   input  logic                 reset,
   pixel_burst_writer_if.master bus
);

   logic              r_a_vld, r_a_eof;
   logic [ADDR_W-1:0] r_a_addr;
   logic [23:0]       r_a_data;
   logic              r_have_prev;
   logic [ADDR_W-1:0] r_prev_addr;
   logic [RUN_W-1:0]  r_run, r_burst_max, r_sent;
   logic [IDLE_W-1:0] r_idle;
   logic              r_overflow, r_frame_done;
   logic [ADDR_W-1:0] r_mem_addr;
   pbw_state_t        r_state, w_state_nxt;

   logic              w_coord_ok, w_full, w_push, w_pop, w_sol, w_start, w_last;
   logic              w_head1_sol;
   logic [CNT_W-1:0]  w_count;
   pbw_entry_t        w_entry;
   pbw_payload_t      w_head;

   assign w_coord_ok = (bus.x_i < 10'(H_ACTIVE)) && (bus.y_i < 10'(V_ACTIVE));
   assign w_full     = (w_count == CNT_W'(DEPTH));
   assign w_push     = r_a_vld && !w_full;
   assign w_pop      = (r_state == ST_DATA) && bus.mem_wready;
   // New run on a gap, on a full run, or on the first entry since reset.
   assign w_sol      = !r_have_prev || (r_a_addr != r_prev_addr + 1'b1) ||
                       (r_run == RUN_W'(BURST_LEN));
   assign w_entry    = '{sol: w_sol, pl: '{eof: r_a_eof, addr: r_a_addr, data: r_a_data}};

   // Stage A: address mapping and range filtering.
   always_ff @(posedge clk_25) begin
      if (!reset) begin
         r_a_vld  <= 1'b0;
         r_a_eof  <= 1'b0;
         r_a_addr <= '0;
         r_a_data <= '0;
      end else begin
         r_a_vld  <= bus.wrreq && w_coord_ok;
         r_a_eof  <= (bus.x_i == 10'(H_ACTIVE - 1)) && (bus.y_i == 10'(V_ACTIVE - 1));
         r_a_addr <= pix_addr(bus.x_i, bus.y_i);
         r_a_data <= {bus.red_i, bus.green_i, bus.blue_i};
      end
   end

   pbw_fifo #(.W(ENTRY_W), .AW(DEPTH_LOG2)) u_fifo (
      .clk_25       (clk_25),
      .reset        (reset),
      .i_push       (w_push),
      .i_wdata      (w_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_head1_flag (w_head1_sol),
      .o_count      (w_count)
   );

   // Push-side bookkeeping: run tracking, overflow flag, idle timer.
   always_ff @(posedge clk_25) begin
      if (!reset) begin
         r_have_prev <= 1'b0;
         r_prev_addr <= '0;
         r_run       <= '0;
         r_overflow  <= 1'b0;
         r_idle      <= '0;
      end else begin
         if (w_push) begin
            r_have_prev <= 1'b1;
            r_prev_addr <= r_a_addr;
            r_run       <= w_sol ? RUN_W'(1) : r_run + 1'b1;
         end
         if (r_a_vld && w_full) r_overflow <= 1'b1;
         if (w_push)                              r_idle <= '0;
         else if (r_idle != IDLE_W'(FLUSH_CYC))   r_idle <= r_idle + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_25) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next state, burst start and end-of-burst decode.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_count >= CNT_W'(BURST_LEN) ||
                (w_count != '0 && r_idle == IDLE_W'(FLUSH_CYC))) begin
               w_state_nxt = ST_REQ;
               w_start     = 1'b1;
            end
         end
         ST_REQ: begin
            if (bus.mem_ack) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_last = (r_sent == r_burst_max - 1'b1) || w_head1_sol;
            if (w_pop && w_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst header latch, word counter and end-of-frame pulse.
   always_ff @(posedge clk_25) begin
      if (!reset) begin
         r_burst_max  <= '0;
         r_sent       <= '0;
         r_mem_addr   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_start) begin
            r_burst_max <= (w_count >= CNT_W'(BURST_LEN)) ? RUN_W'(BURST_LEN) : RUN_W'(w_count);
            r_mem_addr  <= w_head.addr;
            r_sent      <= '0;
         end else if (w_pop) begin
            r_sent <= r_sent + 1'b1;
         end
         r_frame_done <= w_pop && w_head.eof;
      end
   end

   assign bus.mem_req    = (r_state == ST_REQ);
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wvalid = (r_state == ST_DATA);
   assign bus.mem_wlast  = w_last;
   assign bus.mem_wdata  = (r_state == ST_DATA) ? {8'h00, w_head.data} : 32'h0;
   assign bus.overflow   = r_overflow;
   assign bus.frame_done = r_frame_done;

endmodule
